// File: rtl/dds_update_ctrl.sv
// dds_update_ctrl
// Collects frequency/phase/amplitude settings from key_control. It waits until they have
// stopped changing and then until the channel-1 accumulator wraps. It then applies all
// settings to the five-channel DDS core in one cycle, together with an accumulator-clear
// pulse, so the channels stay phase-aligned.
//
// Ports:
//   clk_50m     system clock
//   rst_n       asynchronous active-low reset
//   freq_in     frequency tuning word from key_control
//   phase_in    phase offsets, channel k (1..5) in [32k-1:32k-32]
//   amp_in      signed amplitudes for channels 2..5, channel k in [8k-9:8k-16]
//   acc_msb     MSB of the channel-1 phase accumulator
//   freq_word   applied tuning word
//   phase_word  applied phase offsets (same packing as phase_in)
//   amp_word    applied amplitudes (same packing as amp_in)
//   acc_clr     one-cycle accumulator clear, aligned with the first cycle of new words
//   busy        high while an update is pending
//   upd_cnt     completed-update counter, wraps 255 -> 0
module dds_update_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 50000,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter logic [31:0] RST_FREQ       = 32'd131072
) (
  input  logic         clk_50m,
  input  logic         rst_n,
  input  logic [31:0]  freq_in,
  input  logic [159:0] phase_in,
  input  logic [31:0]  amp_in,
  input  logic         acc_msb,
  output logic [31:0]  freq_word,
  output logic [159:0] phase_word,
  output logic [31:0]  amp_word,
  output logic         acc_clr,
  output logic         busy,
  output logic [7:0]   upd_cnt
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned SetW = 224;

  typedef enum logic [1:0] {StIdle, StSettle, StWaitWrap, StLoad} state_e;

  state_e              state_q, state_d;
  logic [SetW-1:0]     snap_q, snap_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic                acc_msb_q;
  logic [31:0]         freq_q, freq_d;
  logic [159:0]        phase_q, phase_d;
  logic [31:0]         amp_q, amp_d;
  logic                acc_clr_q, acc_clr_d;
  logic                busy_q, busy_d;
  logic [7:0]          upd_cnt_q, upd_cnt_d;

  logic [SetW-1:0]     inputs_w;
  logic [SetW-1:0]     applied_w;
  logic                chg;
  logic                wrap;

  assign inputs_w  = {freq_in, phase_in, amp_in};
  assign applied_w = {freq_q, phase_q, amp_q};
  // Falling edge of the accumulator MSB marks a wrap of channel 1.
  assign wrap      = acc_msb_q & ~acc_msb;
  // In IDLE compare against what is applied; once pending, against the latest snapshot.
  assign chg       = (state_q == StIdle) ? (inputs_w != applied_w) : (inputs_w != snap_q);

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    freq_d    = freq_q;
    phase_d   = phase_q;
    amp_d     = amp_q;
    acc_clr_d = 1'b0;
    busy_d    = busy_q;
    upd_cnt_d = upd_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (chg) begin
          snap_d  = inputs_w;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (chg) begin
          snap_d = inputs_w;
          cnt_d  = '0;
        end else if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = StWaitWrap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitWrap: begin
        // A fresh key step outranks a coincident wrap or timeout.
        if (chg) begin
          snap_d  = inputs_w;
          cnt_d   = '0;
          state_d = StSettle;
        end else if (wrap || (tmr_q == TmrW'(TIMEOUT_CYCLES - 1))) begin
          {freq_d, phase_d, amp_d} = snap_q;
          acc_clr_d = 1'b1;
          upd_cnt_d = upd_cnt_q + 8'd1;
          state_d   = StLoad;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StLoad: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      snap_q    <= {RST_FREQ, 160'd0, 32'd0};
      cnt_q     <= '0;
      tmr_q     <= '0;
      acc_msb_q <= 1'b0;
      freq_q    <= RST_FREQ;
      phase_q   <= '0;
      amp_q     <= '0;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      upd_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      acc_msb_q <= acc_msb;
      freq_q    <= freq_d;
      phase_q   <= phase_d;
      amp_q     <= amp_d;
      acc_clr_q <= acc_clr_d;
      busy_q    <= busy_d;
      upd_cnt_q <= upd_cnt_d;
    end
  end

  assign freq_word  = freq_q;
  assign phase_word = phase_q;
  assign amp_word   = amp_q;
  assign acc_clr    = acc_clr_q;
  assign busy       = busy_q;
  assign upd_cnt    = upd_cnt_q;

endmodule
